// File: rtl/cc1200_spi_pkg.sv
// Shared definitions for the CC1200 SPI/GPIO APB peripheral: register offsets,
// CTRL bit positions and the SPI engine state encoding.
package cc1200_spi_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
    localparam logic [5:0] OFF_TXDATA   = 6'h08;
    localparam logic [5:0] OFF_RXDATA   = 6'h0C;
    localparam logic [5:0] OFF_LEN      = 6'h10;
    localparam logic [5:0] OFF_DIV      = 6'h14;
    localparam logic [5:0] OFF_GPIO_OE  = 6'h18;
    localparam logic [5:0] OFF_GPIO_OUT = 6'h1C;
    localparam logic [5:0] OFF_GPIO_IN  = 6'h20;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/cc1200_spi_engine.sv
// SPI mode-0 master engine: clock divider, transfer FSM and TX/RX shift registers.
// Optional CHIP_RDY_WAIT_EN: SETUP also waits for synchronized MISO low.
module cc1200_spi_engine
    import cc1200_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] tx_data,
    input  logic [1:0]  len,
    input  logic [15:0] div,
    input  logic        miso,
    output logic        busy,
    output logic [31:0] rx_data,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n
);

    spi_state_e  state, state_nxt;
    logic [15:0] h_sh;
    logic [15:0] cnt;
    logic [5:0]  tog;
    logic [5:0]  tog_last;
    logic [1:0]  len_sh;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;
    logic        cnt_done;
    logic        ready;

    assign cnt_done = (cnt == h_sh - 16'd1);
    // 16N toggles per transfer, so the last toggle index is 16N-1
    assign tog_last = {len_sh, 4'hF};
    assign busy     = (state != IDLE);
    assign mosi     = tx_sh[31];

`ifdef CHIP_RDY_WAIT_EN
    logic miso_s1, miso_s2;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end
    assign ready = ~miso_s2;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SETUP;
                SETUP:   if (cnt_done && ready) state_nxt = SHIFT;
                SHIFT:   if (cnt_done && sclk && (tog == tog_last)) state_nxt = HOLD;
                HOLD:    if (cnt_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_sh    <= 16'd0;
            cnt     <= 16'd0;
            tog     <= 6'd0;
            len_sh  <= 2'd0;
            tx_sh   <= 32'd0;
            rx_sh   <= 32'd0;
            rx_data <= 32'd0;
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
        end else if (stop) begin
            cnt   <= 16'd0;
            tx_sh <= 32'd0;
            sclk  <= 1'b0;
            cs_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    h_sh   <= (div == 16'd0) ? 16'd1 : div;
                    len_sh <= len;
                    // left-align the 8N transmitted bits so MOSI is always tx_sh[31]
                    tx_sh  <= tx_data << (5'd24 - {len, 3'b000});
                    rx_sh  <= 32'd0;
                    cnt    <= 16'd0;
                    tog    <= 6'd0;
                    cs_n   <= 1'b0;
                end
                SETUP: begin
                    if (!cnt_done)  cnt <= cnt + 16'd1;
                    else if (ready) cnt <= 16'd0;
                end
                SHIFT: begin
                    if (cnt_done) begin
                        cnt  <= 16'd0;
                        sclk <= ~sclk;
                        tog  <= tog + 6'd1;
                        if (!sclk)                 rx_sh <= {rx_sh[30:0], miso};
                        else if (tog != tog_last)  tx_sh <= tx_sh << 1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        cs_n    <= 1'b1;
                        tx_sh   <= 32'd0;
                        rx_data <= rx_sh;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cc1200_spi_top.sv
// APB3 slave for the CC1200: register file, address decode, GPIO and SPI engine.
// Optional feature macro (in the engine): CHIP_RDY_WAIT_EN.
module cc1200_spi_top
    import cc1200_spi_pkg::*;
#(
    parameter logic [15:0] DIV_RST = 16'd4,
    parameter int          GPIO_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       APB_S_0_paddr,
    input  logic              APB_S_0_psel,
    input  logic              APB_S_0_penable,
    input  logic              APB_S_0_pwrite,
    input  logic [31:0]       APB_S_0_pwdata,
    output logic [31:0]       APB_S_0_prdata,
    output logic              APB_S_0_pready,
    output logic              APB_S_0_pslverr,
    inout  wire  [GPIO_W-1:0] GPIO,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS_n
);

    logic [31:0]       tx_reg;
    logic [3:0]        len_reg;
    logic [15:0]       div_reg;
    logic [GPIO_W-1:0] gpio_oe;
    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_s1, gpio_s2;
    logic [31:0]       rx_data;
    logic [31:0]       rd_mux;
    logic [5:0]        off;
    logic              busy, addr_err, acc, wr, ctrl_wr, spi_start, spi_stop;

    assign off      = APB_S_0_paddr[5:0];
    assign addr_err = (APB_S_0_paddr[31:6] != 26'd0) || (off > OFF_GPIO_IN);
    assign acc      = APB_S_0_psel & APB_S_0_penable;
    assign wr       = acc & APB_S_0_pwrite & ~addr_err;
    assign ctrl_wr  = wr & (off == OFF_CTRL);

    assign APB_S_0_pready  = acc;
    assign APB_S_0_pslverr = acc & addr_err;

    // STOP beats START when both are set in one write
    assign spi_stop  = ctrl_wr & APB_S_0_pwdata[CTRL_STOP];
    assign spi_start = ctrl_wr & APB_S_0_pwdata[CTRL_START] & ~APB_S_0_pwdata[CTRL_STOP];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_reg   <= 32'd0;
            len_reg  <= 4'd0;
            div_reg  <= DIV_RST;
            gpio_oe  <= '0;
            gpio_out <= '0;
        end else if (wr) begin
            case (off)
                OFF_TXDATA:   tx_reg   <= APB_S_0_pwdata;
                OFF_LEN:      len_reg  <= APB_S_0_pwdata[3:0];
                OFF_DIV:      div_reg  <= APB_S_0_pwdata[15:0];
                OFF_GPIO_OE:  gpio_oe  <= APB_S_0_pwdata[GPIO_W-1:0];
                OFF_GPIO_OUT: gpio_out <= APB_S_0_pwdata[GPIO_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (off)
            OFF_STATUS:   rd_mux = {31'd0, busy};
            OFF_TXDATA:   rd_mux = tx_reg;
            OFF_RXDATA:   rd_mux = rx_data;
            OFF_LEN:      rd_mux = {28'd0, len_reg};
            OFF_DIV:      rd_mux = {16'd0, div_reg};
            OFF_GPIO_OE:  rd_mux = {{(32-GPIO_W){1'b0}}, gpio_oe};
            OFF_GPIO_OUT: rd_mux = {{(32-GPIO_W){1'b0}}, gpio_out};
            OFF_GPIO_IN:  rd_mux = {{(32-GPIO_W){1'b0}}, gpio_s2};
            default:      rd_mux = 32'd0;
        endcase
    end

    // read data is captured in the setup phase so it is stable throughout access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            APB_S_0_prdata <= 32'd0;
        end else if (APB_S_0_psel && !APB_S_0_penable && !APB_S_0_pwrite) begin
            APB_S_0_prdata <= addr_err ? 32'd0 : rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= GPIO;
            gpio_s2 <= gpio_s1;
        end
    end

    for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio
        assign GPIO[i] = gpio_oe[i] ? gpio_out[i] : 1'bz;
    end

    cc1200_spi_engine u_engine (
        .clk     (clk),
        .rstn    (rstn),
        .start   (spi_start),
        .stop    (spi_stop),
        .tx_data (tx_reg),
        .len     (len_reg[1:0]),
        .div     (div_reg),
        .miso    (MISO),
        .busy    (busy),
        .rx_data (rx_data),
        .sclk    (SCLK),
        .mosi    (MOSI),
        .cs_n    (CS_n)
    );

endmodule

// File: tb/tb_cc1200_spi_top.sv
// Directed bench for cc1200_spi_top: registers, GPIO, SPI transfer, abort, busy
// protection, address errors and asynchronous reset.
module tb_cc1200_spi_top;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    wire  [3:0]  GPIO;
    logic        SCLK, MOSI, MISO, CS_n;

    logic        gpio_ext_en = 1'b0;
    logic [3:0]  gpio_ext = 4'h0;
    assign GPIO = gpio_ext_en ? gpio_ext : 4'bzzzz;

    int n_vec = 0;
    int n_err = 0;

    int          rise_cnt = 0, fall_cnt = 0, good_period = 0, good_high = 0;
    time         last_rise = 0;
    logic [31:0] mosi_cap = 32'd0;
    logic [31:0] miso_word = 32'd0;
    int          fall_base = 0;
    logic [4:0]  miso_idx;

    assign miso_idx = 5'(31 - (fall_cnt - fall_base));
    assign MISO     = miso_word[miso_idx];

    always #5 clk = ~clk;

    cc1200_spi_top #(.DIV_RST(16'd4), .GPIO_W(4)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .APB_S_0_paddr   (paddr),
        .APB_S_0_psel    (psel),
        .APB_S_0_penable (penable),
        .APB_S_0_pwrite  (pwrite),
        .APB_S_0_pwdata  (pwdata),
        .APB_S_0_prdata  (prdata),
        .APB_S_0_pready  (pready),
        .APB_S_0_pslverr (pslverr),
        .GPIO            (GPIO),
        .SCLK            (SCLK),
        .MOSI            (MOSI),
        .MISO            (MISO),
        .CS_n            (CS_n)
    );

    // clk period 10, so a DIV=4 SCLK has period 80 and high time 40
    always @(posedge SCLK) begin
        if ($time - last_rise == 80) good_period++;
        last_rise = $time;
        rise_cnt++;
        mosi_cap = {mosi_cap[30:0], MOSI};
    end

    always @(negedge SCLK) begin
        if ($time - last_rise == 40) good_high++;
        fall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(posedge clk); #1;
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err,
                            output logic rdy);
        @(posedge clk); #1;
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 d = prdata; err = pslverr; rdy = pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        logic [31:0] d;
        logic e, r;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            apb_read(32'h04, d, e, r);
            if (d[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e, r, ok;
        int          rise0, per0, high0;
        logic [31:0] exp_rst [9];

        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0};

        // reset state
        gpio_ext_en = 1'b1; gpio_ext = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_cs_n", {31'd0, CS_n}, 32'h1);
        check("rst_sclk", {31'd0, SCLK}, 32'h0);
        check("rst_mosi", {31'd0, MOSI}, 32'h0);
        @(negedge clk) rstn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apb_read(32'(i * 4), d, e, r);
            check($sformatf("rst_reg_%02h", i * 4), d, exp_rst[i]);
            check($sformatf("rst_err_%02h", i * 4), {31'd0, e}, 32'h0);
        end
        check("rst_pready", {31'd0, r}, 32'h1);
        gpio_ext_en = 1'b0;

        // GPIO output then input
        apb_write(32'h18, 32'hF, e);
        apb_write(32'h1C, 32'hA, e);
        #1 check("gpio_out_pins", {28'd0, GPIO}, 32'hA);
        apb_read(32'h1C, d, e, r);
        check("gpio_out_reg", d, 32'hA);
        apb_write(32'h18, 32'h0, e);
        gpio_ext = 4'h5; gpio_ext_en = 1'b1;
        repeat (3) @(posedge clk);
        apb_read(32'h20, d, e, r);
        check("gpio_in", d, 32'h5);
        gpio_ext_en = 1'b0;

        // 2-byte transfer
        apb_write(32'h14, 32'd4, e);
        apb_write(32'h10, 32'd1, e);
        apb_write(32'h08, 32'h00B3456D, e);
        miso_word = 32'h12345679; fall_base = fall_cnt;
        rise0 = rise_cnt; per0 = good_period; high0 = good_high;
        apb_write(32'h00, 32'h1, e);
        check("xfer_cs_low", {31'd0, CS_n}, 32'h0);
        check("xfer_first_mosi", {31'd0, MOSI}, 32'h0);
        apb_read(32'h04, d, e, r);
        check("xfer_busy", d, 32'h1);
        wait_idle(ok);
        check("xfer_done", {31'd0, ok}, 32'h1);
        check("xfer_rises", 32'(rise_cnt - rise0), 32'd16);
        check("xfer_period", 32'(good_period - per0), 32'd15);
        check("xfer_high", 32'(good_high - high0), 32'd16);
        check("xfer_mosi", {16'd0, mosi_cap[15:0]}, 32'h456D);
        check("xfer_cs_end", {31'd0, CS_n}, 32'h1);
        check("xfer_mosi_end", {31'd0, MOSI}, 32'h0);
        apb_read(32'h0C, d, e, r);
        check("xfer_rxdata", d, 32'h00001234);

        // abort a 4-byte transfer
        apb_write(32'h10, 32'd3, e);
        apb_write(32'h08, 32'hFFFFFFFF, e);
        miso_word = 32'hFFFFFFFF; fall_base = fall_cnt;
        apb_write(32'h00, 32'h1, e);
        repeat (30) @(posedge clk);
        #1 check("abort_mid_cs", {31'd0, CS_n}, 32'h0);
        apb_write(32'h00, 32'h2, e);
        check("abort_cs", {31'd0, CS_n}, 32'h1);
        check("abort_sclk", {31'd0, SCLK}, 32'h0);
        apb_read(32'h04, d, e, r);
        check("abort_busy", d, 32'h0);
        apb_read(32'h0C, d, e, r);
        check("abort_rxdata", d, 32'h00001234);

        // START+STOP together: nothing starts
        apb_write(32'h00, 32'h3, e);
        check("startstop_cs", {31'd0, CS_n}, 32'h1);
        apb_read(32'h04, d, e, r);
        check("startstop_busy", d, 32'h0);

        // busy protection
        apb_write(32'h10, 32'd1, e);
        apb_write(32'h08, 32'h0000A5C3, e);
        miso_word = 32'hCAFE0000; fall_base = fall_cnt;
        rise0 = rise_cnt;
        apb_write(32'h00, 32'h1, e);
        repeat (20) @(posedge clk);
        apb_write(32'h00, 32'h1, e);
        apb_write(32'h08, 32'hFFFFFFFF, e);
        wait_idle(ok);
        check("busy_done", {31'd0, ok}, 32'h1);
        check("busy_rises", 32'(rise_cnt - rise0), 32'd16);
        check("busy_mosi", {16'd0, mosi_cap[15:0]}, 32'hA5C3);
        apb_read(32'h0C, d, e, r);
        check("busy_rxdata", d, 32'h0000CAFE);

        // address errors
        apb_read(32'h40, d, e, r);
        check("err_rd_slverr", {31'd0, e}, 32'h1);
        check("err_rd_data", d, 32'h0);
        apb_write(32'h24, 32'hFFFFFFFF, e);
        check("err_wr24_slverr", {31'd0, e}, 32'h1);
        apb_write(32'h54, 32'h0000BEEF, e);
        check("err_wr54_slverr", {31'd0, e}, 32'h1);
        apb_read(32'h14, d, e, r);
        check("err_div_kept", d, 32'h4);
        check("err_ok_slverr", {31'd0, e}, 32'h0);
        apb_read(32'h08, d, e, r);
        check("err_tx_kept", d, 32'hFFFFFFFF);

        // asynchronous reset mid-transfer
        apb_write(32'h00, 32'h1, e);
        repeat (20) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_cs", {31'd0, CS_n}, 32'h1);
        check("arst_sclk", {31'd0, SCLK}, 32'h0);
        check("arst_mosi", {31'd0, MOSI}, 32'h0);
        @(negedge clk) rstn = 1'b1;
        apb_read(32'h08, d, e, r);
        check("arst_tx", d, 32'h0);
        apb_read(32'h04, d, e, r);
        check("arst_busy", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cc1200_spi_top.md
Name: cc1200_spi_top

Overview:
- APB3 slave that drives a CC1200 transceiver over a 4-wire SPI master (mode 0, MSB first) and a 4-bit bidirectional GPIO port.
- Software writes the divider, length and TX data, then pulses start. It polls busy and reads the RX data.
- Single clock domain; sits between the processor APB interconnect and the CC1200 pins.

Parameters:
- DIV_RST, 16'd4, reset value of the clock-divider register.
- GPIO_W, 4, GPIO pin count.

Ports:
- clk  in  1  system and APB clock.
- rstn  in  1  reset.
- APB_S_0_paddr  in  32  byte address.
- APB_S_0_psel  in  1  select.
- APB_S_0_penable  in  1  access phase.
- APB_S_0_pwrite  in  1  1 = write.
- APB_S_0_pwdata  in  32  write data.
- APB_S_0_prdata  out  32  read data.
- APB_S_0_pready  out  1  transfer done.
- APB_S_0_pslverr  out  1  error.
- GPIO  inout  GPIO_W  tri-state pins.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- CS_n  out  1  chip select, active low.

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values: SCLK=0, MOSI=0, CS_n=1, GPIO all Z, prdata=0, busy=0, all registers 0 except DIV=DIV_RST.
- APB protocol: zero wait states. pready = psel & penable.
- APB writes commit in the access phase. Reads return registered prdata, valid in the access phase.
- pslverr=1 in the access phase for an offset above 0x20 or paddr[31:6]!=0. Such writes are ignored and such reads return 0.
- Register map:
  - 0x00 CTRL (write-only, self-clearing): bit0 START, bit1 STOP.
  - 0x04 STATUS (read-only): bit0 BUSY.
  - 0x08 TXDATA (32b, read/write).
  - 0x0C RXDATA (read-only).
  - 0x10 LEN [3:0]: bytes = LEN[1:0]+1; bits [3:2] are stored but ignored.
  - 0x14 DIV [15:0].
  - 0x18 GPIO_OE [3:0]: 1 = drive the pin.
  - 0x1C GPIO_OUT [3:0].
  - 0x20 GPIO_IN [3:0] (read-only): pins after a 2-flop synchronizer.
- GPIO: GPIO[i] = GPIO_OE[i] ? GPIO_OUT[i] : Z.
- START while idle: TXDATA, LEN and DIV are latched into shadow registers. BUSY=1 from the next clk. START while busy is ignored.
- Half-period H = max(DIV,1) clk cycles.
- SPI FSM:
  - IDLE -> SETUP on start. CS_n=0 and MOSI = bit 8N-1 of the shadow TX, where N = byte count.
  - SETUP lasts H cycles -> SHIFT.
  - SHIFT: SCLK toggles every H cycles for 16N toggles. MISO is sampled on each rising edge into an RX shift register (shift left). MOSI advances on each falling edge except the last.
  - SHIFT -> HOLD after the last falling edge. HOLD keeps CS_n low for H cycles.
  - HOLD -> IDLE: CS_n=1, MOSI=0, RXDATA = RX shift value (right-aligned, upper bits 0), BUSY=0, all in the same cycle.
- Only the low 8N bits of TXDATA are transmitted.
- STOP at any time: returns to IDLE on the next clk with SCLK=0, CS_n=1, BUSY=0; RXDATA is not updated.
- START and STOP written in the same CTRL write: STOP wins and no transfer starts.
- Register writes during a transfer: take effect on the next transfer only.
- Asynchronous reset mid-transfer: all outputs go to their reset values immediately.

Optional Feature:
- CHIP_RDY_WAIT_EN defined: in SETUP, after the H cycles, the FSM also waits until MISO (2-flop synchronized) reads 0, i.e. CC1200 CHIP_RDYn low, before entering SHIFT. STOP still aborts the wait.
- Not defined: SETUP is a fixed H cycles and MISO is ignored until the first rising edge.

Decomposition:
- Package cc1200_spi_pkg: register offset constants, CTRL bit indices, SPI state enum (IDLE, SETUP, SHIFT, HOLD).
- Sub-module cc1200_spi_engine: divider, FSM and shift registers. Inputs: start, stop, shadow data/length/divider. Outputs: busy, rx data, SPI pins.
- The top level keeps the APB decode, the register file and the GPIO logic.

Test Plan:
- Reset, then read every offset: DIV=0x4, all other registers 0, CS_n=1, SCLK=0, GPIO=Z.
- GPIO: write 0x18=0xF, 0x1C=0xA -> GPIO pins = 4'hA. Write 0x18=0, drive pins externally with 4'h5, read 0x20 -> 0x5.
- Transfer: write DIV=4, LEN=1, TXDATA=0x00B3456D, CTRL=1; MISO streams 0x12345679 MSB first.
  - MOSI = 0x456D MSB first, 16 SCLK pulses of 8 clk period.
  - Poll STATUS until 0, then read RXDATA = 0x00001234.
- Abort: START with LEN=3, write CTRL=2 mid-transfer -> CS_n=1 and BUSY=0 within 1 clk; RXDATA unchanged.
- Busy protection: a second START during a transfer -> no restart and SCLK count unchanged. A TXDATA write mid-transfer does not alter MOSI.
- Error path: read 0x40 -> pslverr=1, prdata=0. Write 0x24 -> pslverr=1 and no register changes.
